// File: rtl/lenet_channel_merge.sv
// lenet_channel_merge: round-robin merge of NUM_CH FIFO-buffered channel streams into one tagged ready/valid stream.
// Optional backpressure stall counter is built only when LENET_MERGE_PERF_EN is defined.
module lenet_channel_merge #(
  parameter int NUM_CH     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CH-1:0]              data_valid_in,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  pixel_in,
  input  logic [NUM_CH-1:0]              layer_done_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_pixel,
  output logic [$clog2(NUM_CH)-1:0]      out_ch,
  output logic                           frame_done,
  output logic [NUM_CH-1:0]              overflow,
  output logic                           busy,
  output logic [31:0]                    perf_stall_cycles
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       cnt_q [NUM_CH];
  logic [AW-1:0]     wp_q  [NUM_CH];
  logic [AW-1:0]     rp_q  [NUM_CH];
  logic [NUM_CH-1:0] done_q, ovf_q, nonempty, full, push, pop;
  logic [CW-1:0]     last_q, grant, idx, out_ch_q;
  logic [DATA_W-1:0] out_pixel_q;
  logic              out_valid_q, found, load, start_acc, wr_en;
  assign load      = !out_valid_q || out_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign wr_en     = (state_q == RUN) || (state_q == DRAIN);
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c] = cnt_q[c] != '0;
      full[c]     = cnt_q[c] == (AW+1)'(FIFO_DEPTH);
    end
  end
  // Round-robin search starts one past the last granted channel
  always_comb begin
    grant = last_q;
    found = 1'b0;
    idx   = '0;
    pop   = '0;
    for (int j = 1; j <= NUM_CH; j++) begin
      idx = CW'((int'(last_q) + j) % NUM_CH);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    if (load && found) pop[grant] = 1'b1;
  end
  // A full FIFO still accepts a write when it is popped in the same cycle
  assign push = {NUM_CH{wr_en}} & data_valid_in & (~full | pop);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = &done_q ? DRAIN : RUN;
      DRAIN:   state_d = (!(|nonempty) && !out_valid_q && !(|data_valid_in)) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push[c]) mem_q[c][wp_q[c]] <= pixel_in[c];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= '0;
      ovf_q       <= '0;
      last_q      <= CW'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_ch_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= start_acc ? '0 : wr_en ? (done_q | layer_done_in) : done_q;
      ovf_q   <= start_acc ? '0 : (ovf_q | ({NUM_CH{wr_en}} & data_valid_in & full & ~pop));
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wp_q[c] <= wp_q[c] + AW'(1);
        if (pop[c])  rp_q[c] <= rp_q[c] + AW'(1);
        cnt_q[c] <= cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      end
      if (load) begin
        out_valid_q <= found;
        if (found) begin
          out_pixel_q <= mem_q[grant][rp_q[grant]];
          out_ch_q    <= grant;
          last_q      <= grant;
        end
      end
    end
  end
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_ch     = out_ch_q;
  assign overflow   = ovf_q;
  assign frame_done = state_q == DONE;
  assign busy       = state_q != IDLE;
`ifdef LENET_MERGE_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else if (start_acc) perf_q <= '0;
    else if (out_valid_q && !out_ready && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end
  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_lenet_channel_merge.sv
// tb_lenet_channel_merge: directed checks of lenet_channel_merge with hand-computed expectations.
module tb_lenet_channel_merge;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [5:0]      data_valid_in = '0;
  logic [5:0][7:0] pixel_in = '0;
  logic [5:0]      layer_done_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      out_pixel;
  logic [2:0]      out_ch;
  logic            frame_done;
  logic [5:0]      overflow;
  logic            busy;
  logic [31:0]     perf_stall_cycles;
  int total = 0;
  int bad = 0;
  lenet_channel_merge #(.NUM_CH(6), .DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .data_valid_in(data_valid_in),
    .pixel_in(pixel_in), .layer_done_in(layer_done_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .out_ch(out_ch),
    .frame_done(frame_done), .overflow(overflow), .busy(busy),
    .perf_stall_cycles(perf_stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pixel", 32'(out_pixel), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perf", perf_stall_cycles, 32'd0);
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    // round-robin: all channels in one cycle
    data_valid_in = 6'h3F;
    for (int i = 0; i < 6; i++) pixel_in[i] = 8'(8'h10 + i);
    step();
    data_valid_in = '0;
    chk("rr_latency", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_ch", 32'(out_ch), 32'(i));
      chk("rr_pixel", 32'(out_pixel), 32'(8'h10 + i));
    end
    step();
    chk("rr_empty", 32'(out_valid), 32'd0);
    // single beat on channel 2
    data_valid_in = 6'b000100;
    pixel_in[2] = 8'h5A;
    step();
    data_valid_in = '0;
    chk("sb_latency", 32'(out_valid), 32'd0);
    step();
    chk("sb_valid", 32'(out_valid), 32'd1);
    chk("sb_pixel", 32'(out_pixel), 32'h5A);
    chk("sb_ch", 32'(out_ch), 32'd2);
    step();
    chk("sb_gone", 32'(out_valid), 32'd0);
    // backpressure: hold a channel-1 beat, then flood channel 0 with 17 pixels
    out_ready = 1'b0;
    data_valid_in = 6'b000010;
    pixel_in[1] = 8'h77;
    step();
    data_valid_in = '0;
    step();
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    chk("bp_held_pixel", 32'(out_pixel), 32'h77);
    for (int n = 0; n < 17; n++) begin
      data_valid_in = 6'b000001;
      pixel_in[0] = 8'(8'h80 + n);
      step();
    end
    data_valid_in = '0;
    chk("bp_overflow", 32'(overflow), 32'h01);
    chk("bp_stable_pixel", 32'(out_pixel), 32'h77);
    chk("bp_stable_ch", 32'(out_ch), 32'd1);
    out_ready = 1'b1;
    step();
    for (int n = 0; n < 16; n++) begin
      chk("bp_beat_valid", 32'(out_valid), 32'd1);
      chk("bp_beat_pixel", 32'(out_pixel), 32'(8'h80 + n));
      chk("bp_beat_ch", 32'(out_ch), 32'd0);
      step();
    end
    chk("bp_drained", 32'(out_valid), 32'd0);
    // done sequencing with 3 pixels buffered
    out_ready = 1'b0;
    data_valid_in = 6'b111000;
    pixel_in[3] = 8'hA0;
    pixel_in[4] = 8'hA1;
    pixel_in[5] = 8'hA2;
    step();
    data_valid_in = '0;
    step();
    for (int i = 0; i < 6; i++) begin
      layer_done_in = 6'(1 << i);
      step();
    end
    layer_done_in = '0;
    step();
    chk("dn_no_early_done", 32'(frame_done), 32'd0);
    chk("dn_first_pixel", 32'(out_pixel), 32'hA0);
    chk("dn_first_ch", 32'(out_ch), 32'd3);
    out_ready = 1'b1;
    step();
    chk("dn_pixel4", 32'(out_pixel), 32'hA1);
    chk("dn_ch4", 32'(out_ch), 32'd4);
    chk("dn_not_yet", 32'(frame_done), 32'd0);
    step();
    chk("dn_pixel5", 32'(out_pixel), 32'hA2);
    chk("dn_ch5", 32'(out_ch), 32'd5);
    step();
    chk("dn_last_accepted", 32'(out_valid), 32'd0);
    chk("dn_not_yet2", 32'(frame_done), 32'd0);
    step();
    chk("dn_pulse", 32'(frame_done), 32'd1);
    chk("dn_busy_during", 32'(busy), 32'd1);
    step();
    chk("dn_pulse_end", 32'(frame_done), 32'd0);
    chk("dn_busy_fall", 32'(busy), 32'd0);
    // reset mid-frame
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    data_valid_in = 6'h3F;
    for (int i = 0; i < 6; i++) pixel_in[i] = 8'(8'hC0 + i);
    step();
    data_valid_in = '0;
    step();
    chk("mr_loaded", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_pixel", 32'(out_pixel), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_perf", perf_stall_cycles, 32'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_beat", 32'(out_valid), 32'd0);
      chk("mr_no_done", 32'(frame_done), 32'd0);
    end
    // stall counter
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    data_valid_in = 6'b000001;
    pixel_in[0] = 8'h42;
    step();
    data_valid_in = '0;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("pf_hold_pixel", 32'(out_pixel), 32'h42);
`ifdef LENET_MERGE_PERF_EN
    chk("pf_count", perf_stall_cycles, 32'd10);
`else
    chk("pf_tied", perf_stall_cycles, 32'd0);
`endif
    out_ready = 1'b1;
    step();
    chk("pf_released", 32'(out_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
